hazard_stall_controller: RTL and testbench

//  Pipeline sequencer for the 5-stage MIPS core, alongside forwarding. Detects load-use hazards

---
 rtl/hazard_stall_controller_pkg.sv | 36 +++
 rtl/hazard_stall_controller_sat_counter.sv | 31 +++
 rtl/hazard_stall_controller.sv | 158 +++++++++++++++
 tb/tb_hazard_stall_controller.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_controller_pkg.sv
// Shared types for the pipeline sequencer: FSM states, per-cycle pipe action,
// pipe-enable bit positions and the load-use hazard term.
package hazard_stall_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ACT_NONE   = 2'd0,
    ACT_FREEZE = 2'd1,
    ACT_FLUSH  = 2'd2,
    ACT_LU     = 2'd3
  } action_t;

  localparam int unsigned PE_PC    = 0;
  localparam int unsigned PE_IFID  = 1;
  localparam int unsigned PE_IDEX  = 2;
  localparam int unsigned PE_EXMEM = 3;
  localparam int unsigned PE_NUM   = 4;

  // $0 is hard-wired zero, so a load targeting it never creates a dependency.
  function automatic logic load_use_hazard(
    input logic       mem_read_ex,
    input logic [4:0] rt_ex,
    input logic [4:0] rs_id,
    input logic [4:0] rt_id,
    input logic       uses_rt_id
  );
    return mem_read_ex && (rt_ex != 5'd0) &&
           ((rt_ex == rs_id) || (uses_rt_id && (rt_ex == rt_id)));
  endfunction

endpackage

// File: rtl/hazard_stall_controller_sat_counter.sv
// Saturating event counter: increments on inc_i, sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer: load-use stalls, memory-wait freeze with watchdog,
// branch flush, and saturating perf counters for each action.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_read_IDEX_i,
  input  logic [4:0]       reg_rt_IDEX_i,
  input  logic [4:0]       reg_rs_IFID_i,
  input  logic [4:0]       reg_rt_IFID_i,
  input  logic             uses_rt_IFID_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_EXMEM_i,
  input  logic             dmem_ready_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             idex_write_o,
  output logic             exmem_write_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             memwb_bubble_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] lu_stall_cnt_o,
  output logic [CNT_W-1:0] mem_wait_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT) + 1;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  action_t           action;
  logic              lu;
  logic              mstall;
  logic [PE_NUM-1:0] pipe_en;
  logic              ifid_flush;
  logic              idex_flush;
  logic              memwb_bubble;

  assign lu = load_use_hazard(mem_read_IDEX_i, reg_rt_IDEX_i, reg_rs_IFID_i,
                              reg_rt_IFID_i, uses_rt_IFID_i);
  assign mstall = dmem_req_EXMEM_i && !dmem_ready_i;

  // The first stalled cycle is spent in RUN and already counts as wait 1,
  // so ERROR is entered after exactly MAX_WAIT frozen cycles.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      ST_RUN: begin
        if (mstall) begin
          state_d = ST_MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (!mstall) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
          state_d = ST_ERROR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Branch or load-use during a freeze is deferred: inputs stay stable while
  // frozen, so the request is simply re-evaluated in the release cycle.
  always_comb begin
    action = ACT_NONE;
    if ((state_q == ST_ERROR) || mstall) begin
      action = ACT_FREEZE;
    end else if (branch_taken_i) begin
      action = ACT_FLUSH;
    end else if (lu) begin
      action = ACT_LU;
    end
  end

  always_comb begin
    pipe_en      = '1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    unique case (action)
      ACT_FREEZE: begin
        pipe_en      = '0;
        memwb_bubble = 1'b1;
      end
      ACT_FLUSH: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      ACT_LU: begin
        pipe_en[PE_PC]   = 1'b0;
        pipe_en[PE_IFID] = 1'b0;
        idex_flush       = 1'b1;
      end
      default: begin
        pipe_en = '1;
      end
    endcase
  end

  assign pc_write_o     = pipe_en[PE_PC];
  assign ifid_write_o   = pipe_en[PE_IFID];
  assign idex_write_o   = pipe_en[PE_IDEX];
  assign exmem_write_o  = pipe_en[PE_EXMEM];
  assign ifid_flush_o   = ifid_flush;
  assign idex_flush_o   = idex_flush;
  assign memwb_bubble_o = memwb_bubble;
  assign mem_timeout_o  = (state_q == ST_ERROR);

  sat_counter #(.W(CNT_W)) u_lu_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (action == ACT_LU),
    .count_o (lu_stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_mem_wait_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (action == ACT_FREEZE),
    .count_o (mem_wait_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (action == ACT_FLUSH),
    .count_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed-vector scoreboard bench for hazard_stall_controller (MAX_WAIT=4, CNT_W=2).
module tb_hazard_stall_controller;

  localparam int unsigned MW = 4;
  localparam int unsigned CW = 2;

  // ctrl = {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush, memwb_bubble}
  localparam logic [6:0] C_RUN    = 7'b1111_000;
  localparam logic [6:0] C_FREEZE = 7'b0000_001;
  localparam logic [6:0] C_FLUSH  = 7'b1111_110;
  localparam logic [6:0] C_LU     = 7'b0011_010;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          mem_read_IDEX_i = 1'b0;
  logic [4:0]    reg_rt_IDEX_i = '0;
  logic [4:0]    reg_rs_IFID_i = '0;
  logic [4:0]    reg_rt_IFID_i = '0;
  logic          uses_rt_IFID_i = 1'b0;
  logic          branch_taken_i = 1'b0;
  logic          dmem_req_EXMEM_i = 1'b0;
  logic          dmem_ready_i = 1'b0;
  logic          pc_write_o, ifid_write_o, idex_write_o, exmem_write_o;
  logic          ifid_flush_o, idex_flush_o, memwb_bubble_o, mem_timeout_o;
  logic [CW-1:0] lu_stall_cnt_o, mem_wait_cnt_o, flush_cnt_o;

  hazard_stall_controller #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_read_IDEX_i  (mem_read_IDEX_i),
    .reg_rt_IDEX_i    (reg_rt_IDEX_i),
    .reg_rs_IFID_i    (reg_rs_IFID_i),
    .reg_rt_IFID_i    (reg_rt_IFID_i),
    .uses_rt_IFID_i   (uses_rt_IFID_i),
    .branch_taken_i   (branch_taken_i),
    .dmem_req_EXMEM_i (dmem_req_EXMEM_i),
    .dmem_ready_i     (dmem_ready_i),
    .pc_write_o       (pc_write_o),
    .ifid_write_o     (ifid_write_o),
    .idex_write_o     (idex_write_o),
    .exmem_write_o    (exmem_write_o),
    .ifid_flush_o     (ifid_flush_o),
    .idex_flush_o     (idex_flush_o),
    .memwb_bubble_o   (memwb_bubble_o),
    .mem_timeout_o    (mem_timeout_o),
    .lu_stall_cnt_o   (lu_stall_cnt_o),
    .mem_wait_cnt_o   (mem_wait_cnt_o),
    .flush_cnt_o      (flush_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [6:0]    ctrl;
    logic          to;
    logic          chk;
    logic [CW-1:0] lu;
    logic [CW-1:0] mw;
    logic [CW-1:0] fl;
  } exp_t;

  exp_t q[$];
  int unsigned asserts = 0;
  int unsigned failures = 0;

  task automatic check(input string nm, input string what, input logic [6:0] got, input logic [6:0] want);
    asserts++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s %s: got %b expected %b", nm, what, got, want);
    end
  endtask

  // Monitor: every cycle that has a queued expectation presents a response.
  exp_t e;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      check(e.name, "ctrl", {pc_write_o, ifid_write_o, idex_write_o, exmem_write_o,
                             ifid_flush_o, idex_flush_o, memwb_bubble_o}, e.ctrl);
      check(e.name, "timeout", {6'b0, mem_timeout_o}, {6'b0, e.to});
      if (e.chk) begin
        check(e.name, "lu_cnt", {5'b0, lu_stall_cnt_o}, {5'b0, e.lu});
        check(e.name, "mw_cnt", {5'b0, mem_wait_cnt_o}, {5'b0, e.mw});
        check(e.name, "fl_cnt", {5'b0, flush_cnt_o}, {5'b0, e.fl});
      end
    end
  end

  task automatic step(input string nm, input logic mr, input logic [4:0] rte,
                      input logic [4:0] rsi, input logic [4:0] rti, input logic ut,
                      input logic br, input logic rq, input logic rd,
                      input logic [6:0] ec, input logic eto, input logic ck,
                      input logic [CW-1:0] elu, input logic [CW-1:0] emw,
                      input logic [CW-1:0] efl);
    exp_t x;
    @(posedge clk);
    #1;
    mem_read_IDEX_i  = mr;
    reg_rt_IDEX_i    = rte;
    reg_rs_IFID_i    = rsi;
    reg_rt_IFID_i    = rti;
    uses_rt_IFID_i   = ut;
    branch_taken_i   = br;
    dmem_req_EXMEM_i = rq;
    dmem_ready_i     = rd;
    x.name = nm; x.ctrl = ec; x.to = eto; x.chk = ck;
    x.lu = elu; x.mw = emw; x.fl = efl;
    q.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b0;
    mem_read_IDEX_i = 1'b0; reg_rt_IDEX_i = '0; reg_rs_IFID_i = '0; reg_rt_IFID_i = '0;
    uses_rt_IFID_i = 1'b0; branch_taken_i = 1'b0; dmem_req_EXMEM_i = 1'b0; dmem_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d expected 0", q.size());
    $fatal(1, "time limit");
  end

  initial begin
    do_reset();
    //    name         mr rte  rsi  rti  ut br rq rd  ctrl      to ck lu mw fl
    step("reset_idle", 0, 0,   0,   0,   0, 0, 0, 0, C_RUN,    0, 1, 0, 0, 0);
    step("lu_rs",      1, 5,   5,   0,   0, 0, 0, 0, C_LU,     0, 1, 0, 0, 0);
    step("lu_after",   0, 0,   0,   0,   0, 0, 0, 0, C_RUN,    0, 1, 1, 0, 0);
    step("lw_r0",      1, 0,   0,   0,   1, 0, 0, 0, C_RUN,    0, 0, 0, 0, 0);
    step("rt_unused",  1, 5,   1,   5,   0, 0, 0, 0, C_RUN,    0, 0, 0, 0, 0);
    step("lu_rt",      1, 5,   1,   5,   1, 0, 0, 0, C_LU,     0, 1, 1, 0, 0);
    step("lu_rt_aft",  0, 0,   0,   0,   0, 0, 0, 0, C_RUN,    0, 1, 2, 0, 0);
    step("mw_1",       0, 0,   0,   0,   0, 0, 1, 0, C_FREEZE, 0, 0, 0, 0, 0);
    step("mw_2",       0, 0,   0,   0,   0, 0, 1, 0, C_FREEZE, 0, 0, 0, 0, 0);
    step("mw_3",       0, 0,   0,   0,   0, 0, 1, 0, C_FREEZE, 0, 0, 0, 0, 0);
    step("mw_ready_lt",0, 0,   0,   0,   0, 0, 1, 1, C_RUN,    0, 1, 2, 3, 0);
    step("mw_after",   0, 0,   0,   0,   0, 0, 0, 0, C_RUN,    0, 1, 2, 3, 0);

    do_reset();
    step("br_mw_1",    0, 0,   0,   0,   0, 1, 1, 0, C_FREEZE, 0, 1, 0, 0, 0);
    step("br_mw_2",    0, 0,   0,   0,   0, 1, 1, 0, C_FREEZE, 0, 0, 0, 0, 0);
    step("br_release", 0, 0,   0,   0,   0, 1, 1, 1, C_FLUSH,  0, 1, 0, 2, 0);
    step("br_after",   0, 0,   0,   0,   0, 0, 0, 0, C_RUN,    0, 1, 0, 2, 1);
    step("br_over_lu", 1, 5,   5,   0,   0, 1, 0, 0, C_FLUSH,  0, 0, 0, 0, 0);
    step("br_lu_aft",  0, 0,   0,   0,   0, 0, 0, 0, C_RUN,    0, 1, 0, 2, 2);
    step("lu_mw_hold", 1, 7,   7,   0,   0, 0, 1, 0, C_FREEZE, 0, 0, 0, 0, 0);
    step("lu_release", 1, 7,   7,   0,   0, 0, 1, 1, C_LU,     0, 0, 0, 0, 0);
    step("lu_rel_aft", 0, 0,   0,   0,   0, 0, 0, 0, C_RUN,    0, 1, 1, 3, 2);

    do_reset();
    for (int i = 0; i < 5; i++)
      step("sat_lu",   1, 9,   3,   9,   1, 0, 0, 0, C_LU,     0, 0, 0, 0, 0);
    step("sat_hold",   0, 0,   0,   0,   0, 0, 0, 0, C_RUN,    0, 1, 3, 0, 0);
    for (int i = 0; i < 4; i++)
      step("wd_wait",  0, 0,   0,   0,   0, 0, 1, 0, C_FREEZE, 0, 0, 0, 0, 0);
    step("wd_error",   0, 0,   0,   0,   0, 0, 0, 0, C_FREEZE, 1, 1, 3, 3, 0);
    step("wd_sticky",  1, 5,   5,   0,   0, 1, 1, 1, C_FREEZE, 1, 0, 0, 0, 0);

    do_reset();
    step("wd_cleared", 0, 0,   0,   0,   0, 0, 0, 0, C_RUN,    0, 1, 0, 0, 0);
    step("drop_1",     0, 0,   0,   0,   0, 0, 1, 0, C_FREEZE, 0, 0, 0, 0, 0);
    step("drop_req",   0, 0,   0,   0,   0, 0, 0, 0, C_RUN,    0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("rewait",   0, 0,   0,   0,   0, 0, 1, 0, C_FREEZE, 0, 0, 0, 0, 0);
    step("rewait_rdy", 0, 0,   0,   0,   0, 0, 1, 1, C_RUN,    0, 0, 0, 0, 0);
    step("rewait_aft", 0, 0,   0,   0,   0, 0, 0, 0, C_RUN,    0, 1, 0, 3, 0);

    do_reset();
    step("mid_lu",     1, 4,   4,   0,   0, 0, 0, 0, C_LU,     0, 0, 0, 0, 0);
    step("mid_mw_1",   0, 0,   0,   0,   0, 0, 1, 0, C_FREEZE, 0, 0, 0, 0, 0);
    step("mid_mw_2",   0, 0,   0,   0,   0, 0, 1, 0, C_FREEZE, 0, 1, 1, 1, 0);
    do_reset();
    step("mid_reset",  0, 0,   0,   0,   0, 0, 0, 0, C_RUN,    0, 1, 0, 0, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    asserts++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
